// File: rtl/binary_to_tc_11.sv
// binary_to_tc_11: two-stage valid/ready pipeline that encodes a 4-bit
// binary value into a thermometer code for residues modulo the modulus.
module binary_to_tc_11 #(
   parameter  int MOD  = 11,
   localparam int TC_W = MOD - 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [3:0]      in_bin,
   input  logic            in_valid,
   output logic            in_ready,
   output logic [TC_W:1]   out_tc,
   output logic            out_ovf,
   output logic            out_valid,
   input  logic            out_ready
);

   logic            s1_valid_q, s1_valid_d;
   logic [3:0]      s1_res_q, s1_res_d;
   logic            s1_ovf_q, s1_ovf_d;
   logic            out_valid_q, out_valid_d;
   logic [TC_W:1]   out_tc_q, out_tc_d;
   logic            out_ovf_q, out_ovf_d;

   logic            in_fire;
   logic            out_fire;
   logic            s2_load;
   logic            in_ovf;
   logic [3:0]      in_res;
   logic [TC_W:1]   tc_enc;

   always_comb begin
      in_ovf = (int'(in_bin) >= MOD);
`ifdef TC11_WRAP_EN
      in_res = 4'(int'(in_bin) % MOD);
`else
      in_res = in_ovf ? 4'd0 : in_bin;
`endif
   end

   always_comb begin
      tc_enc = '0;
      for (int i = 1; i <= TC_W; i++) begin
         tc_enc[i] = (i <= int'(s1_res_q));
      end
   end

   assign s2_load  = s1_valid_q && (!out_valid_q || out_ready);
   assign in_ready = !rst && (!s1_valid_q || !out_valid_q || out_ready);
   assign in_fire  = in_valid && in_ready;
   assign out_fire = out_valid_q && out_ready;

   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_res_d    = s1_res_q;
      s1_ovf_d    = s1_ovf_q;
      out_valid_d = out_valid_q;
      out_tc_d    = out_tc_q;
      out_ovf_d   = out_ovf_q;

      if (s2_load) begin
         s1_valid_d = 1'b0;
      end
      if (in_fire) begin
         s1_valid_d = 1'b1;
         s1_res_d   = in_res;
         s1_ovf_d   = in_ovf;
      end

      if (out_fire) begin
         out_valid_d = 1'b0;
      end
      if (s2_load) begin
         out_valid_d = 1'b1;
         out_tc_d    = tc_enc;
         out_ovf_d   = s1_ovf_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_res_q    <= '0;
         s1_ovf_q    <= 1'b0;
         out_valid_q <= 1'b0;
         out_tc_q    <= '0;
         out_ovf_q   <= 1'b0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_res_q    <= s1_res_d;
         s1_ovf_q    <= s1_ovf_d;
         out_valid_q <= out_valid_d;
         out_tc_q    <= out_tc_d;
         out_ovf_q   <= out_ovf_d;
      end
   end

   assign out_tc    = out_tc_q;
   assign out_ovf   = out_ovf_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_binary_to_tc_11.sv
// tb_binary_to_tc_11: directed and randomized checks of the
// thermometer encoder pipeline at MOD=11 and MOD=5.
module tb_binary_to_tc_11;

   localparam int TC_W = 10;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [3:0]      in_bin = '0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [TC_W:1]   out_tc;
   logic            out_ovf;
   logic            out_valid;
   logic            out_ready = 1'b0;

   logic [3:0]      in_bin5 = '0;
   logic            in_valid5 = 1'b0;
   logic            in_ready5;
   logic [4:1]      out_tc5;
   logic            out_ovf5;
   logic            out_valid5;
   logic            out_ready5 = 1'b1;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   binary_to_tc_11 dut (
      .clk       (clk),
      .rst       (rst),
      .in_bin    (in_bin),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_tc    (out_tc),
      .out_ovf   (out_ovf),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   binary_to_tc_11 #(.MOD(5)) u5 (
      .clk       (clk),
      .rst       (rst),
      .in_bin    (in_bin5),
      .in_valid  (in_valid5),
      .in_ready  (in_ready5),
      .out_tc    (out_tc5),
      .out_ovf   (out_ovf5),
      .out_valid (out_valid5),
      .out_ready (out_ready5)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [TC_W:1] tab(input int r);
      case (r)
         0:  tab = 10'h000;
         1:  tab = 10'h001;
         2:  tab = 10'h003;
         3:  tab = 10'h007;
         4:  tab = 10'h00F;
         5:  tab = 10'h01F;
         6:  tab = 10'h03F;
         7:  tab = 10'h07F;
         8:  tab = 10'h0FF;
         9:  tab = 10'h1FF;
         default: tab = 10'h3FF;
      endcase
   endfunction

   // Reference: repeated subtraction and bitwise build of the code.
   function automatic void model(input logic [3:0] b,
                                 output logic [TC_W:1] tc,
                                 output logic ovf);
      int r;
      r = int'(b);
      ovf = (r >= 11);
      while (r >= 11) r = r - 11;
`ifndef TC11_WRAP_EN
      if (ovf) r = 0;
`endif
      tc = '0;
      for (int i = 1; i <= TC_W; i++) begin
         if (i <= r) tc[i] = 1'b1;
      end
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b1;
      in_bin = 4'd3;
      out_ready = 1'b1;
      tick();
      tick();
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_in_ready: got %b want 0", in_ready);
      end
      checks++;
      if (out_valid !== 1'b0 || out_tc !== '0 || out_ovf !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: got v=%b tc=%h ovf=%b want 0/000/0",
                  out_valid, out_tc, out_ovf);
      end
      in_valid = 1'b0;
      rst = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_ready: got %b want 1", in_ready);
      end
   endtask

   task automatic test_stream();
      logic exp_v;
      out_ready = 1'b1;
      for (int c = 0; c < 13; c++) begin
         in_valid = (c <= 10);
         in_bin = 4'((c <= 10) ? c : 0);
         tick();
         exp_v = (c >= 1 && c <= 11);
         checks++;
         if (out_valid !== exp_v) begin
            errors++;
            $display("FAIL stream_valid c=%0d: got %b want %b",
                     c, out_valid, exp_v);
         end else if (exp_v) begin
            checks++;
            if (out_tc !== tab(c - 1) || out_ovf !== 1'b0) begin
               errors++;
               $display("FAIL stream_data c=%0d: got %h/%b want %h/0",
                        c, out_tc, out_ovf, tab(c - 1));
            end
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic test_ovf();
      logic [3:0]    v  [4] = '{4'd13, 4'd11, 4'd15, 4'd10};
`ifdef TC11_WRAP_EN
      logic [TC_W:1] et [4] = '{10'h003, 10'h000, 10'h00F, 10'h3FF};
`else
      logic [TC_W:1] et [4] = '{10'h000, 10'h000, 10'h000, 10'h3FF};
`endif
      logic          eo [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_bin = v[i];
         tick();
         in_valid = 1'b0;
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_tc !== et[i] || out_ovf !== eo[i]) begin
            errors++;
            $display("FAIL ovf in=%0d: got v=%b tc=%h ovf=%b want 1/%h/%b",
                     v[i], out_valid, out_tc, out_ovf, et[i], eo[i]);
         end
         tick();
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0]    src [3] = '{4'd3, 4'd7, 4'd9};
      logic [TC_W:1] got [3];
      int            idx = 0;
      int            n = 0;
      logic          fire;
      out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         in_valid = (idx < 3);
         in_bin = src[(idx < 3) ? idx : 2];
         #1;
         fire = in_valid && in_ready;
         tick();
         if (fire) idx++;
         if (out_valid === 1'b1) begin
            checks++;
            if (out_tc !== 10'h007) begin
               errors++;
               $display("FAIL hold_tc c=%0d: got %h want 007", c, out_tc);
            end
         end
      end
      checks++;
      if (idx !== 2 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL stall_state: got acc=%0d rdy=%b v=%b want 2/0/1",
                  idx, in_ready, out_valid);
      end
      out_ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         in_valid = (idx < 3);
         in_bin = src[(idx < 3) ? idx : 2];
         #1;
         fire = in_valid && in_ready;
         if (out_valid && out_ready) begin
            if (n < 3) got[n] = out_tc;
            n++;
         end
         tick();
         if (fire) idx++;
      end
      in_valid = 1'b0;
      checks++;
      if (n !== 3) begin
         errors++;
         $display("FAIL release_count: got %0d want 3", n);
      end else begin
         checks++;
         if (got[0] !== 10'h007 || got[1] !== 10'h07F || got[2] !== 10'h1FF) begin
            errors++;
            $display("FAIL release_order: got %h,%h,%h want 007,07F,1FF",
                     got[0], got[1], got[2]);
         end
      end
   endtask

   task automatic test_random();
      logic [TC_W:1] q_tc [$];
      logic          q_ovf [$];
      logic [TC_W:1] etc, prev_tc;
      logic          eov, prev_ovf;
      logic          held = 1'b0;
      int            sent = 0;
      int            recv = 0;
      int            cyc = 0;
      while (recv < 1000 && cyc < 20000) begin
         in_valid = (sent < 1000) && ($urandom_range(0, 3) != 0);
         in_bin = 4'($urandom_range(0, 15));
         out_ready = ($urandom_range(0, 2) != 0);
         #1;
         if (held) begin
            checks++;
            if (out_valid !== 1'b1 || out_tc !== prev_tc || out_ovf !== prev_ovf) begin
               errors++;
               $display("FAIL rand_stable cyc=%0d: got %b/%h/%b want 1/%h/%b",
                        cyc, out_valid, out_tc, out_ovf, prev_tc, prev_ovf);
            end
         end
         if (in_valid && in_ready) begin
            model(in_bin, etc, eov);
            q_tc.push_back(etc);
            q_ovf.push_back(eov);
            sent++;
         end
         if (out_valid && out_ready) begin
            checks++;
            if (q_tc.size() == 0) begin
               errors++;
               $display("FAIL rand_extra cyc=%0d: got %h want no item",
                        cyc, out_tc);
            end else begin
               etc = q_tc.pop_front();
               eov = q_ovf.pop_front();
               if (out_tc !== etc || out_ovf !== eov) begin
                  errors++;
                  $display("FAIL rand_data item=%0d: got %h/%b want %h/%b",
                           recv, out_tc, out_ovf, etc, eov);
               end
            end
            recv++;
         end
         held = out_valid && !out_ready;
         prev_tc = out_tc;
         prev_ovf = out_ovf;
         tick();
         cyc++;
      end
      checks++;
      if (recv != 1000 || q_tc.size() != 0) begin
         errors++;
         $display("FAIL rand_count: got recv=%0d left=%0d want 1000/0",
                  recv, q_tc.size());
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
   endtask

   task automatic test_reset_midstream();
      logic seen = 1'b0;
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_bin = 4'd5;
      tick();
      in_bin = 4'd6;
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL midrst_full: got v=%b rdy=%b want 1/0",
                  out_valid, in_ready);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || out_tc !== '0 || out_ovf !== 1'b0) begin
         errors++;
         $display("FAIL midrst_clear: got %b/%h/%b want 0/000/0",
                  out_valid, out_tc, out_ovf);
      end
      out_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         tick();
         if (out_valid !== 1'b0) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         errors++;
         $display("FAIL midrst_ghost: got stale item %h want none", out_tc);
      end
   endtask

   task automatic test_mod5();
      logic [3:0] v  [3] = '{4'd4, 4'd7, 4'd5};
`ifdef TC11_WRAP_EN
      logic [4:1] et [3] = '{4'hF, 4'h3, 4'h0};
`else
      logic [4:1] et [3] = '{4'hF, 4'h0, 4'h0};
`endif
      logic       eo [3] = '{1'b0, 1'b1, 1'b1};
      out_ready5 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid5 = 1'b1;
         in_bin5 = v[i];
         tick();
         in_valid5 = 1'b0;
         tick();
         checks++;
         if (out_valid5 !== 1'b1 || out_tc5 !== et[i] || out_ovf5 !== eo[i]) begin
            errors++;
            $display("FAIL mod5 in=%0d: got v=%b tc=%h ovf=%b want 1/%h/%b",
                     v[i], out_valid5, out_tc5, out_ovf5, et[i], eo[i]);
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_ovf();
      test_back_to_back();
      test_random();
      test_reset_midstream();
      test_mod5();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
